eq_band_mixer: RTL and testbench

Combines the per-band 48-bit outputs of the equalizer FIR bank into one 24-bit stereo sample per audio frame. It applies a per-band gain, accumulates the bands through one time-shared multiplier per channel, then rounds and saturates. The result goes to the I2S transmit path over a valid/ready handshake. The block consumes the FIR bank's valid strobe and band-output arrays, and takes gain writes from the same control register path that loads FIR coefficients.

---
 rtl/eq_mix_pkg.sv | 25 ++
 rtl/eq_band_mac.sv | 54 +++++
 rtl/eq_band_mixer.sv | 198 +++++++++++++++++++
 tb/tb_eq_band_mixer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_mix_pkg.sv
// Shared widths, saturation limits, FSM encoding and output payload for the EQ band mixer.
package eq_mix_pkg;

  localparam int unsigned GAIN_W = 8;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h80;
  localparam int unsigned BAND_W = 48;
  localparam int unsigned ACC_W  = 60;
  localparam int unsigned OUT_W  = 24;

  localparam logic signed [OUT_W-1:0] OUT_MAX = 24'sh7FFFFF;
  localparam logic signed [OUT_W-1:0] OUT_MIN = 24'sh800000;

  typedef enum logic [1:0] {
    IDLE,
    CAP,
    MAC,
    RND
  } state_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] l;
    logic signed [OUT_W-1:0] r;
  } sample_t;

endpackage

// File: rtl/eq_band_mac.sv
// One channel of the band mixer: gain multiply, 60-bit accumulate, round half up and saturate.
module eq_band_mac
  import eq_mix_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    mac_en,
  input  logic signed [BAND_W-1:0] band,
  input  logic [GAIN_W-1:0]       gain,
  output logic signed [OUT_W-1:0] result_c,
  output logic                    sat_c
);

  localparam int unsigned PROD_W = BAND_W + GAIN_W + 1;
  localparam int unsigned RND_W  = ACC_W + 1;
  localparam int unsigned SHIFT  = OUT_SHIFT + GAIN_W - 1;
  localparam logic signed [RND_W-1:0] BIAS = RND_W'(64'd1 << (SHIFT - 1));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [RND_W-1:0]  biased;
  logic signed [RND_W-1:0]  shifted;

  // Gain is unsigned, so it is zero-extended into a positive signed operand.
  assign prod    = PROD_W'(band) * PROD_W'($signed({1'b0, gain}));
  assign biased  = RND_W'(acc) + BIAS;
  assign shifted = biased >>> SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    sat_c    = 1'b0;
    result_c = shifted[OUT_W-1:0];
    if (shifted > RND_W'(OUT_MAX)) begin
      sat_c    = 1'b1;
      result_c = OUT_MAX;
    end else if (shifted < RND_W'(OUT_MIN)) begin
      sat_c    = 1'b1;
      result_c = OUT_MIN;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Mixes the FIR bank's per-band outputs into one gained, rounded, saturated stereo sample per frame.
module eq_band_mixer
  import eq_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS = 4,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        audio_en,
  input  logic                        gain_wr_en,
  input  logic [5:0]                  gain_select,
  input  logic [GAIN_W-1:0]           gain_wr_data,
  input  logic                        status_clr,
  input  logic                        fir_valid,
  input  logic [BAND_W*NUM_BANDS-1:0] l_band_in,
  input  logic [BAND_W*NUM_BANDS-1:0] r_band_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            l_out,
  output logic [OUT_W-1:0]            r_out,
  output logic                        busy,
  output logic                        clip,
  output logic                        overrun
);

  localparam int unsigned K_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_BANDS - 1);

  state_t state;
  state_t state_next;

  logic [K_W-1:0]           k;
  logic signed [BAND_W-1:0] l_snap    [NUM_BANDS];
  logic signed [BAND_W-1:0] r_snap    [NUM_BANDS];
  logic [GAIN_W-1:0]        gain      [NUM_BANDS];
  logic [GAIN_W-1:0]        gain_snap [NUM_BANDS];
  sample_t                  out_q;

  logic accept_c;
  logic drop_c;
  logic acc_clr_c;
  logic mac_en_c;
  logic load_c;
  logic ovw_c;
  logic l_sat_c;
  logic r_sat_c;
  logic signed [OUT_W-1:0] l_res_c;
  logic signed [OUT_W-1:0] r_res_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; disabling audio forces the frame to abandon.
  always_comb begin
    state_next = state;
    if (!audio_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (fir_valid) state_next = CAP;
        CAP:     state_next = MAC;
        MAC:     if (k == K_LAST) state_next = RND;
        RND:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept_c  = 1'b0;
    drop_c    = 1'b0;
    acc_clr_c = !audio_en;
    mac_en_c  = 1'b0;
    load_c    = 1'b0;
    if (audio_en) begin
      drop_c = fir_valid && (state != IDLE);
      case (state)
        IDLE:    accept_c  = fir_valid;
        CAP:     acc_clr_c = 1'b1;
        MAC:     mac_en_c  = 1'b1;
        RND:     load_c    = 1'b1;
        default: ;
      endcase
    end
    ovw_c = load_c && out_valid && !out_ready;
  end

  // Gain registers; writes to bands beyond NUM_BANDS are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) gain[i] <= GAIN_UNITY;
    end else if (gain_wr_en && (gain_select < 6'(NUM_BANDS))) begin
      gain[gain_select[K_W-1:0]] <= gain_wr_data;
    end
  end

  // Bands and gains are frozen on acceptance so later writes cannot disturb the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        l_snap[i]    <= '0;
        r_snap[i]    <= '0;
        gain_snap[i] <= GAIN_UNITY;
      end
    end else if (accept_c) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        l_snap[i]    <= l_band_in[i*BAND_W +: BAND_W];
        r_snap[i]    <= r_band_in[i*BAND_W +: BAND_W];
        gain_snap[i] <= gain[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k <= '0;
    end else if (acc_clr_c) begin
      k <= '0;
    end else if (mac_en_c) begin
      k <= k + K_W'(1);
    end
  end

  eq_band_mac #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac_l (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (acc_clr_c),
    .mac_en   (mac_en_c),
    .band     (l_snap[k]),
    .gain     (gain_snap[k]),
    .result_c (l_res_c),
    .sat_c    (l_sat_c)
  );

  eq_band_mac #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac_r (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (acc_clr_c),
    .mac_en   (mac_en_c),
    .band     (r_snap[k]),
    .gain     (gain_snap[k]),
    .result_c (r_res_c),
    .sat_c    (r_sat_c)
  );

  // Output handshake, busy and sticky status; a set always beats status_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      busy      <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);

      if (!audio_en) begin
        out_valid <= 1'b0;
      end else if (load_c) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_c) begin
        out_q <= '{l: l_res_c, r: r_res_c};
      end

      if (load_c && (l_sat_c || r_sat_c)) begin
        clip <= 1'b1;
      end else if (status_clr) begin
        clip <= 1'b0;
      end

      if (drop_c || ovw_c) begin
        overrun <= 1'b1;
      end else if (status_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign l_out = out_q.l;
  assign r_out = out_q.r;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: table vectors, hand-timed corner sequences and a sample scoreboard.
module tb_eq_band_mixer;

  localparam int unsigned NB = 4;
  localparam int unsigned BW = 48;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           audio_en;
  logic           gain_wr_en;
  logic [5:0]     gain_select;
  logic [7:0]     gain_wr_data;
  logic           status_clr;
  logic           fir_valid;
  logic [BW*NB-1:0] l_band_in;
  logic [BW*NB-1:0] r_band_in;
  logic           out_ready;
  logic           out_valid;
  logic [23:0]    l_out;
  logic [23:0]    r_out;
  logic           busy;
  logic           clip;
  logic           overrun;

  eq_band_mixer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_en     (audio_en),
    .gain_wr_en   (gain_wr_en),
    .gain_select  (gain_select),
    .gain_wr_data (gain_wr_data),
    .status_clr   (status_clr),
    .fir_valid    (fir_valid),
    .l_band_in    (l_band_in),
    .r_band_in    (r_band_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .l_out        (l_out),
    .r_out        (r_out),
    .busy         (busy),
    .clip         (clip),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef longint band_t [NB];
  typedef logic [7:0] gains_t [NB];
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } want_t;
  typedef struct {
    band_t       l;
    band_t       r;
    gains_t      g;
    bit          wr_g;
    logic [23:0] el;
    logic [23:0] er;
    logic        eclip;
  } vec_t;

  want_t  want_q[$];
  gains_t gm;
  vec_t   tbl[5];
  int     tests = 0;
  int     fails = 0;

  // Reference channel: exact 64-bit sum, round half up, clamp to 24-bit signed.
  function automatic logic [23:0] chan(input band_t b, input gains_t g, output bit c);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < int'(NB); i++) acc += b[i] * longint'(g[i]);
    r = (acc + (longint'(1) <<< 21)) >>> 22;
    c = 1'b0;
    if (r > 64'sd8388607) begin
      c = 1'b1;
      return 24'h7FFFFF;
    end
    if (r < -64'sd8388608) begin
      c = 1'b1;
      return 24'h800000;
    end
    return r[23:0];
  endfunction

  function automatic longint rnd_band();
    logic [47:0] raw;
    raw = 48'({$urandom(), $urandom()});
    return longint'($signed(raw)) >>> $urandom_range(0, 30);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock: score any accepted sample at the negedge, then step past the next posedge.
  task automatic cyc();
    want_t w;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (want_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: got l_out 0x%0h r_out 0x%0h, expected no sample", l_out, r_out);
      end else begin
        w = want_q.pop_front();
        check("l_out", 64'(l_out), 64'(w.l));
        check("r_out", 64'(r_out), 64'(w.r));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_gain(input int idx, input logic [7:0] val);
    gain_select  = 6'(idx);
    gain_wr_data = val;
    gain_wr_en   = 1'b1;
    cyc();
    gain_wr_en = 1'b0;
    if (idx < int'(NB)) gm[idx] = val;
  endtask

  task automatic send(input band_t l, input band_t r, input bit push);
    want_t w;
    bit cl;
    bit cr;
    for (int i = 0; i < int'(NB); i++) begin
      l_band_in[i*BW +: BW] = l[i][47:0];
      r_band_in[i*BW +: BW] = r[i][47:0];
    end
    if (push) begin
      w.l = chan(l, gm, cl);
      w.r = chan(r, gm, cr);
      want_q.push_back(w);
    end
    fir_valid = 1'b1;
    cyc();
    fir_valid = 1'b0;
  endtask

  task automatic clear_status();
    status_clr = 1'b1;
    cyc();
    status_clr = 1'b0;
  endtask

  initial begin
    band_t bl;
    band_t br;
    want_t w;

    reset_n = 1'b0; audio_en = 1'b1; gain_wr_en = 1'b0; gain_select = '0;
    gain_wr_data = '0; status_clr = 1'b0; fir_valid = 1'b0; out_ready = 1'b1;
    l_band_in = '0; r_band_in = '0;
    for (int i = 0; i < int'(NB); i++) gm[i] = 8'h80;

    tbl[0].l = '{64'h123456 << 15, 0, 0, 0};
    tbl[0].r = '{-64'sd49152, 0, 0, 0};
    tbl[0].g = '{8'h80, 8'h80, 8'h80, 8'h80}; tbl[0].wr_g = 1'b0;
    tbl[0].el = 24'h123456; tbl[0].er = 24'hFFFFFF; tbl[0].eclip = 1'b0;
    tbl[1].l = '{64'h3FFFFF << 15, 64'h3FFFFF << 15, 64'h3FFFFF << 15, 64'h3FFFFF << 15};
    tbl[1].r = '{0, 0, 0, 0};
    tbl[1].g = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; tbl[1].wr_g = 1'b1;
    tbl[1].el = 24'h7FFFFF; tbl[1].er = 24'h000000; tbl[1].eclip = 1'b1;
    tbl[2].l = '{-(64'sd1 <<< 37), -(64'sd1 <<< 37), -(64'sd1 <<< 37), -(64'sd1 <<< 37)};
    tbl[2].r = '{0, 64'h100 << 15, 0, 0};
    tbl[2].g = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; tbl[2].wr_g = 1'b1;
    tbl[2].el = 24'h800000; tbl[2].er = 24'h0001FE; tbl[2].eclip = 1'b1;
    tbl[3].l = '{64'sd16384, 0, 0, 0};
    tbl[3].r = '{-64'sd16384, 0, 0, 0};
    tbl[3].g = '{8'h80, 8'h80, 8'h80, 8'h80}; tbl[3].wr_g = 1'b1;
    tbl[3].el = 24'h000001; tbl[3].er = 24'h000000; tbl[3].eclip = 1'b0;
    tbl[4].l = '{64'h10 << 15, 64'h20 << 15, 64'h30 << 15, 64'h40 << 15};
    tbl[4].r = '{0, 0, 0, 0};
    tbl[4].g = '{8'h80, 8'h40, 8'h00, 8'hFF}; tbl[4].wr_g = 1'b1;
    tbl[4].el = 24'h0000A0; tbl[4].er = 24'h000000; tbl[4].eclip = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_l_out", 64'(l_out), 64'd0);
    check("rst_r_out", 64'(r_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clip", 64'(clip), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Table vectors with hand-derived expected samples and clip.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].wr_g) for (int b = 0; b < int'(NB); b++) write_gain(b, tbl[i].g[b]);
      w.l = tbl[i].el;
      w.r = tbl[i].er;
      want_q.push_back(w);
      send(tbl[i].l, tbl[i].r, 1'b0);
      wait_n(9);
      check($sformatf("clip_v%0d", i), 64'(clip), 64'(tbl[i].eclip));
      clear_status();
      check($sformatf("clip_clr_v%0d", i), 64'(clip), 64'd0);
    end

    // Latency: out_valid appears seven edges after fir_valid; out-of-range gain write ignored.
    for (int b = 0; b < int'(NB); b++) write_gain(b, 8'h80);
    write_gain(9, 8'h00);
    bl = '{64'h1234 << 15, 64'h10 << 15, 0, 0};
    br = '{0, 0, 0, -(64'sd85 <<< 15)};
    send(bl, br, 1'b1);
    check("busy_cap", 64'(busy), 64'd1);
    wait_n(5);
    check("valid_early", 64'(out_valid), 64'd0);
    check("busy_rnd", 64'(busy), 64'd1);
    cyc();
    check("valid_cycle7", 64'(out_valid), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    wait_n(2);
    check("valid_fall", 64'(out_valid), 64'd0);

    // Gain write during MAC only affects the following frame.
    bl = '{64'h100 << 15, 64'h200 << 15, 0, 0};
    send(bl, bl, 1'b1);
    wait_n(2);
    write_gain(1, 8'h00);
    wait_n(6);
    send(bl, bl, 1'b1);
    wait_n(9);
    write_gain(1, 8'h80);

    // Back-pressure: hold, overwrite, same-cycle reload.
    out_ready = 1'b0;
    bl = '{64'h111 << 15, 0, 0, 0};
    send(bl, bl, 1'b1);
    wait_n(20);
    check("held_valid", 64'(out_valid), 64'd1);
    check("held_l", 64'(l_out), 64'(want_q[0].l));
    check("held_no_overrun", 64'(overrun), 64'd0);
    bl = '{64'h222 << 15, 0, 0, 0};
    send(bl, bl, 1'b1);
    wait_n(7);
    check("overrun_overwrite", 64'(overrun), 64'd1);
    check("overwrite_valid", 64'(out_valid), 64'd1);
    void'(want_q.pop_front());
    check("overwrite_l", 64'(l_out), 64'(want_q[0].l));
    clear_status();
    check("overrun_clr", 64'(overrun), 64'd0);
    bl = '{64'h333 << 15, 64'h1 << 15, 0, 0};
    send(bl, bl, 1'b1);
    wait_n(5);
    out_ready = 1'b1;
    cyc();
    check("reload_valid", 64'(out_valid), 64'd1);
    check("reload_no_overrun", 64'(overrun), 64'd0);
    cyc();
    cyc();
    check("reload_fall", 64'(out_valid), 64'd0);

    // fir_valid while busy is dropped.
    bl = '{64'h44 << 15, 0, 0, 0};
    send(bl, bl, 1'b1);
    cyc();
    send(bl, bl, 1'b0);
    wait_n(9);
    check("overrun_drop", 64'(overrun), 64'd1);
    clear_status();

    // audio_en low in RND suppresses the sample; gains survive.
    write_gain(0, 8'h40);
    bl = '{64'h100 << 15, 0, 0, 0};
    send(bl, bl, 1'b0);
    wait_n(5);
    audio_en = 1'b0;
    cyc();
    check("disable_valid", 64'(out_valid), 64'd0);
    check("disable_busy", 64'(busy), 64'd0);
    audio_en = 1'b1;
    wait_n(3);
    send(bl, bl, 1'b1);
    wait_n(9);

    // Asynchronous reset mid-MAC.
    send(bl, bl, 1'b0);
    cyc();
    send(bl, bl, 1'b0);
    check("pre_reset_overrun", 64'(overrun), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overrun", 64'(overrun), 64'd0);
    check("mid_rst_l_out", 64'(l_out), 64'd0);
    check("mid_rst_r_out", 64'(r_out), 64'd0);
    wait_n(2);
    reset_n = 1'b1;
    for (int i = 0; i < int'(NB); i++) gm[i] = 8'h80;
    wait_n(10);
    send(bl, bl, 1'b1);
    wait_n(9);

    // Random frames against the reference model.
    for (int n = 0; n < 6; n++) begin
      for (int b = 0; b < int'(NB); b++) write_gain(b, 8'($urandom()));
      for (int b = 0; b < int'(NB); b++) begin
        bl[b] = rnd_band();
        br[b] = rnd_band();
      end
      send(bl, br, 1'b1);
      wait_n(9);
    end
    clear_status();

    wait_n(5);
    check("queue_empty", 64'(want_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
